regfile_scoreboard: RTL and testbench

Parametrised register file built from NUM_REGS width-generic enabled registers.
- Two combinational read ports and one synchronous write port.
- Optional write-to-read bypass.
- Per-register busy scoreboard: the decode stage reserves a destination, writeback clears it, and hazard logic uses the busy flags to stall.
- Sits between decode and writeback in the pipelined datapath.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/register_nbits.sv | 17 +
 rtl/regfile_scoreboard.sv | 77 +++++++
 tb/tb_regfile_scoreboard.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file / scoreboard slice.
package regfile_pkg;
    localparam int DEFAULT_WIDTH    = 16;
    localparam int DEFAULT_NUM_REGS = 8;
    localparam int REG_ZERO         = 0;

    function automatic int calcAddrW(input int numRegs);
        return (numRegs > 1) ? $clog2(numRegs) : 1;
    endfunction
endpackage

// File: rtl/register_nbits.sv
// Width-generic enabled register with synchronous active-high reset.
module register_nbits #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk) begin
        if (rst)
            q <= '0;
        else if (en)
            q <= d;
    end
endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with two combinational read ports, one write port, optional
// write-to-read bypass and a per-register busy scoreboard for hazard stalls.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int NUM_REGS = DEFAULT_NUM_REGS,
    parameter int ADDR_W   = calcAddrW(NUM_REGS),
    parameter bit BYPASS   = 1'b1,
    parameter bit R0_ZERO  = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] read1RegSel,
    input  logic [ADDR_W-1:0] read2RegSel,
    output logic [WIDTH-1:0]  read1Data,
    output logic [WIDTH-1:0]  read2Data,
    input  logic [ADDR_W-1:0] writeRegSel,
    input  logic [WIDTH-1:0]  writeData,
    input  logic              writeEn,
    input  logic              reserveEn,
    input  logic [ADDR_W-1:0] reserveRegSel,
    output logic              busy1,
    output logic              busy2,
    output logic              wawErr
);
    logic [NUM_REGS-1:0][WIDTH-1:0] regQ;
    logic [NUM_REGS-1:0]            busyQ;
    logic                           wrEff;
    logic                           rsvEff;
    logic                           fwd1;
    logic                           fwd2;

    // With a hardwired zero register, traffic aimed at it is dropped up front
    // so it can never be written, forwarded or reserved.
    assign wrEff  = writeEn   && !(R0_ZERO && (writeRegSel   == ADDR_W'(REG_ZERO)));
    assign rsvEff = reserveEn && !(R0_ZERO && (reserveRegSel == ADDR_W'(REG_ZERO)));

    for (genvar i = 0; i < NUM_REGS; i++) begin : gReg
        register_nbits #(.WIDTH(WIDTH)) uReg (
            .clk (clk),
            .rst (rst),
            .en  (wrEff && (writeRegSel == ADDR_W'(i))),
            .d   (writeData),
            .q   (regQ[i])
        );
    end

    assign fwd1 = BYPASS && wrEff && (writeRegSel == read1RegSel);
    assign fwd2 = BYPASS && wrEff && (writeRegSel == read2RegSel);

    always_comb begin
        read1Data = fwd1 ? writeData : regQ[read1RegSel];
        read2Data = fwd2 ? writeData : regQ[read2RegSel];
        // A forwarded value satisfies the consumer, so the hazard is hidden.
        busy1     = busyQ[read1RegSel] && !fwd1;
        busy2     = busyQ[read2RegSel] && !fwd2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busyQ  <= '0;
            wawErr <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                // Reserve beats clear: the newer producer is still in flight.
                if (rsvEff && (reserveRegSel == ADDR_W'(i)))
                    busyQ[i] <= 1'b1;
                else if (wrEff && (writeRegSel == ADDR_W'(i)))
                    busyQ[i] <= 1'b0;
            end
            if (rsvEff && busyQ[reserveRegSel] &&
                !(wrEff && (writeRegSel == reserveRegSel)))
                wawErr <= 1'b1;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench: default build plus BYPASS=0 and R0_ZERO=1 builds on shared inputs.
module tb_regfile_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  read1RegSel, read2RegSel, writeRegSel, reserveRegSel;
    logic [15:0] writeData;
    logic        writeEn, reserveEn;

    logic [15:0] r1Data, r2Data, nbR1Data, nbR2Data, zR1Data, zR2Data;
    logic        b1, b2, waw, nbB1, nbB2, nbWaw, zB1, zB2, zWaw;

    int nChecks = 0;
    int nFail   = 0;

    always #5 clk = ~clk;

    regfile_scoreboard #(.BYPASS(1'b1), .R0_ZERO(1'b0)) dut (
        .clk(clk), .rst(rst), .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
        .read1Data(r1Data), .read2Data(r2Data), .writeRegSel(writeRegSel),
        .writeData(writeData), .writeEn(writeEn), .reserveEn(reserveEn),
        .reserveRegSel(reserveRegSel), .busy1(b1), .busy2(b2), .wawErr(waw));

    regfile_scoreboard #(.BYPASS(1'b0), .R0_ZERO(1'b0)) dutNb (
        .clk(clk), .rst(rst), .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
        .read1Data(nbR1Data), .read2Data(nbR2Data), .writeRegSel(writeRegSel),
        .writeData(writeData), .writeEn(writeEn), .reserveEn(reserveEn),
        .reserveRegSel(reserveRegSel), .busy1(nbB1), .busy2(nbB2), .wawErr(nbWaw));

    regfile_scoreboard #(.BYPASS(1'b1), .R0_ZERO(1'b1)) dutZ (
        .clk(clk), .rst(rst), .read1RegSel(read1RegSel), .read2RegSel(read2RegSel),
        .read1Data(zR1Data), .read2Data(zR2Data), .writeRegSel(writeRegSel),
        .writeData(writeData), .writeEn(writeEn), .reserveEn(reserveEn),
        .reserveRegSel(reserveRegSel), .busy1(zB1), .busy2(zB2), .wawErr(zWaw));

    typedef struct {
        logic        wEn;
        logic [2:0]  wSel;
        logic [15:0] wData;
        logic        rsvEn;
        logic [2:0]  rsvSel;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic [15:0] e1;
        logic [15:0] e2;
        logic        eb1;
        logic        eb2;
        logic        eWaw;
        logic [15:0] eNb1;
        logic        eNbB1;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s [%0d]: got 0x%04h expected 0x%04h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle's inputs mid-period; outputs settle before the next rising edge.
    task automatic step(input logic r, input logic wEn, input logic [2:0] wSel,
                        input logic [15:0] wData, input logic rsvEn, input logic [2:0] rsvSel,
                        input logic [2:0] r1, input logic [2:0] r2);
        @(negedge clk);
        rst = r; writeEn = wEn; writeRegSel = wSel; writeData = wData;
        reserveEn = rsvEn; reserveRegSel = rsvSel; read1RegSel = r1; read2RegSel = r2;
        #1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd3, 3'd5, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[1]  = '{1'b1, 3'd2, 16'hBEEF, 1'b0, 3'd0, 3'd2, 3'd3, 16'hBEEF, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[2]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd2, 3'd2, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'hBEEF, 1'b0};
        vecs[3]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd4, 3'd4, 3'd2, 16'h0000, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[4]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd4, 3'd4, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
        vecs[5]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd4, 3'd2, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[6]  = '{1'b1, 3'd4, 16'h1234, 1'b0, 3'd0, 3'd4, 3'd4, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[7]  = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd4, 3'd2, 16'h1234, 16'hBEEF, 1'b0, 1'b0, 1'b0, 16'h1234, 1'b0};
        vecs[8]  = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd6, 3'd6, 3'd0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0};
        vecs[9]  = '{1'b1, 3'd6, 16'h5A5A, 1'b1, 3'd6, 3'd6, 3'd4, 16'h5A5A, 16'h1234, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1};
        vecs[10] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd6, 3'd6, 16'h5A5A, 16'h5A5A, 1'b1, 1'b1, 1'b0, 16'h5A5A, 1'b1};
        vecs[11] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd1, 3'd6, 16'h0000, 16'h5A5A, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0};
        vecs[12] = '{1'b0, 3'd0, 16'h0000, 1'b1, 3'd1, 3'd1, 3'd6, 16'h0000, 16'h5A5A, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1};
        vecs[13] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd1, 3'd7, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1};
        vecs[14] = '{1'b1, 3'd1, 16'h0101, 1'b0, 3'd0, 3'd1, 3'd1, 16'h0101, 16'h0101, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1};
        vecs[15] = '{1'b1, 3'd7, 16'h7777, 1'b1, 3'd3, 3'd7, 3'd3, 16'h7777, 16'h0000, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0};
        vecs[16] = '{1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 3'd7, 3'd3, 16'h7777, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h7777, 1'b0};

        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);

        for (int i = 0; i < 17; i++) begin
            step(1'b0, vecs[i].wEn, vecs[i].wSel, vecs[i].wData, vecs[i].rsvEn,
                 vecs[i].rsvSel, vecs[i].r1, vecs[i].r2);
            check("read1Data", i, r1Data, vecs[i].e1);
            check("read2Data", i, r2Data, vecs[i].e2);
            check("busy1",     i, 16'(b1), 16'(vecs[i].eb1));
            check("busy2",     i, 16'(b2), 16'(vecs[i].eb2));
            check("wawErr",    i, 16'(waw), 16'(vecs[i].eWaw));
            check("nb.read1Data", i, nbR1Data, vecs[i].eNb1);
            check("nb.busy1",     i, 16'(nbB1), 16'(vecs[i].eNbB1));
            check("nb.wawErr",    i, 16'(nbWaw), 16'(vecs[i].eWaw));
            check("z.read1Data",  i, zR1Data, vecs[i].e1);
            check("z.busy1",      i, 16'(zB1), 16'(vecs[i].eb1));
        end

        // Reset overrides a simultaneous write and reserve; clears busy and sticky error.
        step(1'b1, 1'b1, 3'd5, 16'h1111, 1'b1, 3'd5, 3'd3, 3'd6);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd3, 3'd5);
        check("rst.read1Data", 100, r1Data, 16'h0000);
        check("rst.read2Data", 100, r2Data, 16'h0000);
        check("rst.busy1",     100, 16'(b1), 16'h0);
        check("rst.busy2",     100, 16'(b2), 16'h0);
        check("rst.wawErr",    100, 16'(waw), 16'h0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd6, 3'd7);
        check("rst.read1Data", 101, r1Data, 16'h0000);
        check("rst.read2Data", 101, r2Data, 16'h0000);

        // Register 0 traffic: hardwired zero build ignores it, normal build does not.
        step(1'b0, 1'b1, 3'd0, 16'hFFFF, 1'b1, 3'd0, 3'd0, 3'd0);
        check("z.r0.read1Data", 200, zR1Data, 16'h0000);
        check("z.r0.read2Data", 200, zR2Data, 16'h0000);
        check("z.r0.busy1",     200, 16'(zB1), 16'h0);
        check("r0.read1Data",   200, r1Data, 16'hFFFF);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd0, 3'd0);
        check("z.r0.read1Data", 201, zR1Data, 16'h0000);
        check("z.r0.busy1",     201, 16'(zB1), 16'h0);
        check("z.r0.wawErr",    201, 16'(zWaw), 16'h0);
        check("r0.read1Data",   201, r1Data, 16'hFFFF);
        check("r0.busy1",       201, 16'(b1), 16'h1);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd0, 3'd0);
        check("z.r0.wawErr",    202, 16'(zWaw), 16'h0);
        check("z.r0.busy2",     202, 16'(zB2), 16'h0);
        check("r0.wawErr",      202, 16'(waw), 16'h1);

        // Reset while register 5 is busy with fresh data.
        step(1'b0, 1'b1, 3'd5, 16'h5555, 1'b1, 3'd5, 3'd5, 3'd0);
        check("z.r5.read1Data", 300, zR1Data, 16'h5555);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd5, 3'd0);
        check("z.r5.read1Data", 301, zR1Data, 16'h5555);
        check("z.r5.busy1",     301, 16'(zB1), 16'h1);
        step(1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd5, 3'd0);
        step(1'b0, 1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 3'd5, 3'd0);
        check("z.r5.read1Data", 302, zR1Data, 16'h0000);
        check("z.r5.busy1",     302, 16'(zB1), 16'h0);
        check("z.wawErr",       302, 16'(zWaw), 16'h0);
        check("wawErr",         302, 16'(waw), 16'h0);
        check("r0.read2Data",   302, r2Data, 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end
endmodule
